fft_sdf_sequencer: RTL and testbench



---
 rtl/fft_pkg.sv | 17 +
 rtl/fft_sdf_sequencer_if.sv | 11 +
 rtl/fft_stage_ctrl_gen.sv | 19 +
 rtl/fft_sdf_sequencer.sv | 70 +++++++
 tb/tb_fft_sdf_sequencer.sv | 141 ++++++++++++++
 5 files changed

// File: rtl/fft_pkg.sv
// fft_pkg: shared types, default transform width and index helpers for the SDF FFT sequencer.
package fft_pkg;
    localparam int L = 10;
    typedef enum logic [1:0] {IDLE, RUN, DRAIN} seq_state_t;
    function automatic int stage_offset(input int s, input int n);
        int o;
        o = 0;
        for (int j = 0; j < s; j++) o += n >> (j + 1);
        return o;
    endfunction
    function automatic logic [31:0] bitrev(input logic [31:0] x, input int w);
        logic [31:0] r;
        r = '0;
        for (int i = 0; i < w; i++) r[i] = x[w-1-i];
        return r;
    endfunction
endpackage

// File: rtl/fft_sdf_sequencer_if.sv
// fft_sdf_sequencer_if: source/stage-chain side signals of the SDF FFT sequencer.
interface fft_sdf_sequencer_if import fft_pkg::*; #(parameter int LW = L);
    logic in_valid, in_sof, flush;
    logic enable, zero_inject, out_valid, out_sof, busy, frame_err;
    logic [LW-1:0] stage_ctrl, out_index;
    logic [LW*LW-1:0] stage_addr;
    modport master(input in_valid, in_sof, flush,
                   output enable, zero_inject, stage_ctrl, stage_addr, out_valid, out_sof, out_index, busy, frame_err);
    modport slave(output in_valid, in_sof, flush,
                  input enable, zero_inject, stage_ctrl, stage_addr, out_valid, out_sof, out_index, busy, frame_err);
endinterface

// File: rtl/fft_stage_ctrl_gen.sv
// fft_stage_ctrl_gen: maps the global count to one stage's ctrl select and twiddle address.
module fft_stage_ctrl_gen import fft_pkg::*; #(
    parameter int FFT_N = 1024,
    parameter int S = 0
) (
    input  logic [$clog2(FFT_N)-1:0] cnt,
    output logic                     ctrl,
    output logic [$clog2(FFT_N)-1:0] addr
);
    localparam int LW = $clog2(FFT_N);
    localparam logic [LW-1:0] OFF = LW'(stage_offset(S, FFT_N));
    localparam logic [LW-1:0] MASK = LW'((1 << (LW - 1 - S)) - 1);
    logic [LW-1:0] loc;
    always_comb begin
        loc = cnt - OFF;
        ctrl = loc[LW-1-S];
        addr = loc & MASK;
    end
endmodule

// File: rtl/fft_sdf_sequencer.sv
// fft_sdf_sequencer: enable/ctrl/twiddle sequencing, fill/drain tracking and output bin tagging for an SDF radix-2 FFT.
// Optional FFT_SEQ_FRAME_CHECK_EN: in_sof resynchronises the count and sets a sticky frame_err.
module fft_sdf_sequencer import fft_pkg::*; #(
    parameter int FFT_N = 1024
) (
    input logic clk,
    input logic rst,
    fft_sdf_sequencer_if.master bus
);
    localparam int LW = $clog2(FFT_N);
    localparam logic [LW-1:0] LAT = LW'(FFT_N - 1);
    seq_state_t state_q, state_d;
    logic [LW-1:0] cnt_q, cnt_d, fill_q, fill_d, ocnt_q, ocnt_d, dcnt_q, dcnt_d, cnt_e, fill_e;
    logic [LW-1:0] ctrl_w;
    logic [LW*LW-1:0] addr_w;
    logic en, ov, done, resync;
`ifdef FFT_SEQ_FRAME_CHECK_EN
    logic err_q, err_d;
    assign resync = en && bus.in_sof && cnt_q != '0;
    assign err_d = err_q | resync;
    always_ff @(posedge clk) err_q <= rst ? 1'b0 : err_d;
    assign bus.frame_err = err_q;
`else
    assign resync = 1'b0;
    assign bus.frame_err = 1'b0;
`endif
    always_comb begin
        en = state_q == DRAIN || bus.in_valid;
        done = state_q == DRAIN && dcnt_q == LAT - 1'b1;
        cnt_e = resync ? '0 : cnt_q;
        fill_e = resync ? '0 : fill_q;
        ov = en && fill_e == LAT;
        state_d = state_q == IDLE ? (bus.in_valid ? RUN : IDLE) :
                  state_q == RUN ? (bus.flush ? DRAIN : RUN) : (done ? IDLE : DRAIN);
        cnt_d = done ? '0 : en ? cnt_e + 1'b1 : cnt_q;
        fill_d = done ? '0 : en && !ov ? fill_e + 1'b1 : fill_e;
        ocnt_d = done ? '0 : ov ? ocnt_q + 1'b1 : ocnt_q;
        dcnt_d = state_q == DRAIN && !done ? dcnt_q + 1'b1 : '0;
    end
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            cnt_q <= '0;
            fill_q <= '0;
            ocnt_q <= '0;
            dcnt_q <= '0;
        end else begin
            state_q <= state_d;
            cnt_q <= cnt_d;
            fill_q <= fill_d;
            ocnt_q <= ocnt_d;
            dcnt_q <= dcnt_d;
        end
    end
    for (genvar s = 0; s < LW; s++) begin : g_stage
        fft_stage_ctrl_gen #(.FFT_N(FFT_N), .S(s)) u_gen (
            .cnt(cnt_e),
            .ctrl(ctrl_w[s]),
            .addr(addr_w[s*LW +: LW])
        );
    end
    assign bus.enable = en;
    assign bus.zero_inject = state_q == DRAIN;
    assign bus.busy = state_q != IDLE;
    assign bus.out_valid = ov;
    assign bus.out_sof = ov && ocnt_q == '0;
    assign bus.out_index = LW'(bitrev(32'(ocnt_q), LW));
    assign bus.stage_ctrl = ctrl_w;
    assign bus.stage_addr = addr_w;
endmodule

// File: tb/tb_fft_sdf_sequencer.sv
// tb_fft_sdf_sequencer: directed checks of the 16-point sequencer (fill, stall, drain, reset, frame check).
module tb_fft_sdf_sequencer;
    logic clk = 1'b0;
    logic rst = 1'b1;
    int n_chk = 0;
    int n_bad = 0;
    int kk = 0;
    int rev[16] = '{0, 8, 4, 12, 2, 10, 6, 14, 1, 9, 5, 13, 3, 11, 7, 15};
    fft_sdf_sequencer_if #(.LW(4)) sif ();
    fft_sdf_sequencer #(.FFT_N(16)) dut (.clk(clk), .rst(rst), .bus(sif));
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic chk_held();
        int oc;
        oc = kk >= 15 ? kk - 15 : 0;
        chk("ctrl0", 32'(sif.stage_ctrl[0]), 32'((kk % 16) / 8));
        chk("addr0", 32'(sif.stage_addr[3:0]), 32'(kk % 8));
        chk("index", 32'(sif.out_index), 32'(rev[oc % 16]));
    endtask

    task automatic stream(input int n, input int stall_at);
        for (int i = 0; i < n; i++) begin
            if (i == stall_at) begin
                for (int j = 0; j < 5; j++) begin
                    @(negedge clk);
                    sif.in_valid = 1'b0;
                    #1;
                    chk("stall_en", 32'(sif.enable), 0);
                    chk("stall_ov", 32'(sif.out_valid), 0);
                    chk_held();
                    if (kk % 16 == 5) begin
                        chk("stall_ctrl", 32'(sif.stage_ctrl), 32'hA);
                        chk("stall_addr", 32'(sif.stage_addr), 32'h0115);
                    end
                end
            end
            @(negedge clk);
            sif.in_valid = 1'b1;
            #1;
            chk("en", 32'(sif.enable), 1);
            chk("ov", 32'(sif.out_valid), 32'(kk >= 15));
            chk("sof", 32'(sif.out_sof), 32'(kk >= 15 && (kk - 15) % 16 == 0));
            chk_held();
            kk++;
        end
    endtask

    task automatic chk_idle(input string tag);
        chk({tag, "_busy"}, 32'(sif.busy), 0);
        chk({tag, "_en"}, 32'(sif.enable), 0);
        chk({tag, "_zi"}, 32'(sif.zero_inject), 0);
        chk({tag, "_ov"}, 32'(sif.out_valid), 0);
        chk({tag, "_ctrl"}, 32'(sif.stage_ctrl), 0);
        chk({tag, "_addr"}, 32'(sif.stage_addr), 0);
        chk({tag, "_idx"}, 32'(sif.out_index), 0);
        chk({tag, "_err"}, 32'(sif.frame_err), 0);
    endtask

    initial begin
        sif.in_valid = 1'b0;
        sif.in_sof = 1'b0;
        sif.flush = 1'b0;
        repeat (2) @(negedge clk);
        #1;
        chk_idle("reset");
        @(negedge clk);
        rst = 1'b0;
        stream(48, 21);
        @(negedge clk);
        sif.in_valid = 1'b0;
        sif.flush = 1'b1;
        #1;
        chk("flush_busy", 32'(sif.busy), 1);
        chk("flush_zi", 32'(sif.zero_inject), 0);
        for (int j = 0; j < 15; j++) begin
            @(negedge clk);
            sif.flush = 1'b0;
            #1;
            chk("drain_en", 32'(sif.enable), 1);
            chk("drain_zi", 32'(sif.zero_inject), 1);
            chk("drain_ov", 32'(sif.out_valid), 1);
            chk("drain_sof", 32'(sif.out_sof), 0);
            chk("drain_idx", 32'(sif.out_index), 32'(rev[j + 1]));
        end
        @(negedge clk);
        #1;
        chk_idle("drained");
        kk = 0;
        stream(32, -1);
        @(negedge clk);
        sif.in_valid = 1'b0;
        sif.flush = 1'b1;
        for (int j = 0; j < 3; j++) begin
            @(negedge clk);
            sif.flush = 1'b0;
            #1;
            chk("drain2_zi", 32'(sif.zero_inject), 1);
        end
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        #1;
        chk_idle("rst_drain");
        kk = 0;
        stream(21, -1);
        @(negedge clk);
        sif.in_valid = 1'b1;
        sif.in_sof = 1'b1;
        #1;
`ifdef FFT_SEQ_FRAME_CHECK_EN
        chk("sof_addr0", 32'(sif.stage_addr[3:0]), 0);
        chk("sof_ov", 32'(sif.out_valid), 0);
`else
        chk("sof_addr0", 32'(sif.stage_addr[3:0]), 5);
        chk("sof_ov", 32'(sif.out_valid), 1);
`endif
        @(negedge clk);
        sif.in_valid = 1'b0;
        sif.in_sof = 1'b0;
        #1;
`ifdef FFT_SEQ_FRAME_CHECK_EN
        chk("sof_err", 32'(sif.frame_err), 1);
        chk("sof_cnt", 32'(sif.stage_addr[3:0]), 1);
`else
        chk("sof_err", 32'(sif.frame_err), 0);
        chk("sof_cnt", 32'(sif.stage_addr[3:0]), 6);
`endif
        chk("sof_ctrl0", 32'(sif.stage_ctrl[0]), 0);
        $display("test done: total=%0d bad=%0d", n_chk, n_bad);
        $finish;
    end
endmodule
